cache_control: RTL
==================

// Module: cache_control
// PURPOSE
//  Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1 cache datapath.
//  It sits between the CPU memory port and physical memory, and drives every load, mux-select
//  and data-in control of the datapath. It resolves hits and performs dirty-victim writeback
//  and line fill. It also keeps saturating hit/miss/writeback event counters for performance debug.
// PARAMETERS
//  CNT_WIDTH  16  width of each event counter; counters saturate at all-ones
// PORTS
//  clk            in   1   single clock; all state changes on rising edge
//  reset          in   1   synchronous, active-high
//  mem_read       in   1   CPU read request, held until mem_resp
//  mem_write      in   1   CPU write request, held until mem_resp
//  mem_resp       out  1   CPU request complete (1-cycle pulse)
//  pmem_read      out  1   physical line read, held until pmem_resp
//  pmem_write     out  1   physical line write, held until pmem_resp
//  pmem_resp      in   1   physical transfer complete
//  hit, hit2_out  in   1   datapath hit status; hit2_out=1 means way 2 hit
//  valid1_out, valid2_out, dirty1_out, dirty2_out, lru_out  in  1 each
//                          set status; lru_out = victim way (0=way1, 1=way2)
//  load_tag1/2, load_valid1/2, load_data1/2, load_dirty1/2, load_lru  out  1 each
//                          array write enables
//  valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in  out  1 each
//                          array write data
//  writemux1_sel, writemux2_sel  out  1   0=pmem_rdata (fill), 1=CPU byte-merge
//  pmem_write_sel out  1   0=way1 data, 1=way2 data to pmem_wdata
//  pmem_sel       out  1   0=mem_address (fill), 1=victim tag/index address (writeback)
//  hit_count, miss_count, wb_count  out  CNT_WIDTH  event counters
// BEHAVIOUR
//  Reset: state=IDLE, victim_q=0, all counters=0, every output=0.
//   Datapath arrays are not cleared by reset.
//  Default, every cycle: all outputs 0 unless asserted below.
//  States: IDLE, WRITEBACK, FILL.
//  req = mem_read|mem_write. When both are set, the request is a write.
//  IDLE, req & hit: same-cycle mem_resp=1; load_lru=1; lru_in=~hit2_out.
//   Write hit also: load_dataN=1, writemuxN_sel=1, load_dirtyN=1, dirtyN_in=1 (N = hit way).
//   hit_count++. Stay in IDLE.
//  IDLE, req & ~hit: victim_q<=lru_out; miss_count++.
//   Victim valid & dirty -> WRITEBACK (wb_count++). Otherwise -> FILL.
//  WRITEBACK: pmem_write=1, pmem_sel=1, pmem_write_sel=victim_q.
//   pmem_resp -> FILL. No array writes.
//  FILL: pmem_read=1, pmem_sel=0.
//   On pmem_resp write way victim_q: load_data=1 (writemux_sel=0), load_tag=1,
//   load_valid=1 (valid_in=1), load_dirty=1 (dirty_in=0). Then -> IDLE.
//  After a fill, the request is re-evaluated in IDLE the next cycle, hits, and completes there.
//   Miss latency = fill pmem latency + 1, plus writeback latency if dirty.
//  The victim way comes from victim_q, never the live lru_out, in WRITEBACK and FILL.
//  CPU request dropped mid-miss: the pmem transaction still completes, then IDLE, no mem_resp.
//  pmem_resp outside WRITEBACK/FILL is ignored.
//  Reset mid-miss: pmem_read/pmem_write deassert in the cycle after reset is sampled.
//   No array write occurs.
//  mem_resp is never asserted outside IDLE. pmem_read and pmem_write are never both 1.
//  Counters saturate at 2^CNT_WIDTH-1 with no wrap. Hit and miss are exclusive per request.
//   A post-fill hit is not counted.
// TESTING
//  Read hit way1 (valid1=1, tag match): mem_read=1 -> mem_resp same cycle, load_lru=1,
//   lru_in=1, hit_count=1.
//  Write hit way2, byte_enable=2'b01 -> mem_resp same cycle, load_data2=1, writemux2_sel=1,
//   dirty2_in=1, lru_in=0.
//  Clean miss (lru_out=0, valid1=0), pmem_resp after 5 cycles -> FILL, pmem_read=1, pmem_sel=0.
//   Then load_tag1/data1/valid1=1 with dirty1_in=0, then IDLE hit, mem_resp; miss_count=1, wb_count=0.
//  Dirty miss (lru_out=1, valid2=dirty2=1) -> WRITEBACK: pmem_write=1, pmem_sel=1,
//   pmem_write_sel=1; on pmem_resp -> FILL into way2; wb_count=1.
//  Assert reset during FILL, pmem_resp pending -> next cycle IDLE, pmem_read=0,
//   no load_* pulse, counters=0.
//  CNT_WIDTH=2, 5 read hits -> hit_count saturates at 3.

Source files
------------

// File: rtl/cache_control.sv
// Control sequencer for a 2-way set-associative, write-back, write-allocate L1 cache.
// It resolves hits in IDLE, writes back a dirty victim, fills the line and keeps saturating event counters.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit,
    input  logic                 hit2_out,
    input  logic                 valid1_out,
    input  logic                 valid2_out,
    input  logic                 dirty1_out,
    input  logic                 dirty2_out,
    input  logic                 lru_out,
    output logic                 load_tag1,
    output logic                 load_tag2,
    output logic                 load_valid1,
    output logic                 load_valid2,
    output logic                 load_data1,
    output logic                 load_data2,
    output logic                 load_dirty1,
    output logic                 load_dirty2,
    output logic                 load_lru,
    output logic                 valid1_in,
    output logic                 valid2_in,
    output logic                 dirty1_in,
    output logic                 dirty2_in,
    output logic                 lru_in,
    output logic                 writemux1_sel,
    output logic                 writemux2_sel,
    output logic                 pmem_write_sel,
    output logic                 pmem_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_victim;
    logic   r_post_fill;
    logic   w_req;
    logic   w_victim_dirty;
    logic [2:0] w_evt;                    // {wb, miss, hit} count enables
    logic [CNT_WIDTH-1:0] w_cnt [3];

    assign w_req          = mem_read | mem_write;
    assign w_victim_dirty = lru_out ? (valid2_out & dirty2_out) : (valid1_out & dirty1_out);

    always_comb begin
        w_state_next   = r_state;
        w_evt          = '0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        load_tag1      = 1'b0;
        load_tag2      = 1'b0;
        load_valid1    = 1'b0;
        load_valid2    = 1'b0;
        load_data1     = 1'b0;
        load_data2     = 1'b0;
        load_dirty1    = 1'b0;
        load_dirty2    = 1'b0;
        load_lru       = 1'b0;
        valid1_in      = 1'b0;
        valid2_in      = 1'b0;
        dirty1_in      = 1'b0;
        dirty2_in      = 1'b0;
        lru_in         = 1'b0;
        writemux1_sel  = 1'b0;
        writemux2_sel  = 1'b0;
        pmem_write_sel = 1'b0;
        pmem_sel       = 1'b0;
        // Outputs are held low while reset is asserted so nothing reaches the arrays or pmem.
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit2_out;
                        if (mem_write) begin
                            if (hit2_out) begin
                                load_data2    = 1'b1;
                                writemux2_sel = 1'b1;
                                load_dirty2   = 1'b1;
                                dirty2_in     = 1'b1;
                            end else begin
                                load_data1    = 1'b1;
                                writemux1_sel = 1'b1;
                                load_dirty1   = 1'b1;
                                dirty1_in     = 1'b1;
                            end
                        end
                        w_evt[0] = ~r_post_fill;
                    end else if (w_req) begin
                        w_evt[1] = 1'b1;
                        if (w_victim_dirty) begin
                            w_evt[2]     = 1'b1;
                            w_state_next = S_WRITEBACK;
                        end else begin
                            w_state_next = S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write     = 1'b1;
                    pmem_sel       = 1'b1;
                    pmem_write_sel = r_victim;
                    if (pmem_resp) begin
                        w_state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        if (r_victim) begin
                            load_data2  = 1'b1;
                            load_tag2   = 1'b1;
                            load_valid2 = 1'b1;
                            valid2_in   = 1'b1;
                            load_dirty2 = 1'b1;
                        end else begin
                            load_data1  = 1'b1;
                            load_tag1   = 1'b1;
                            load_valid1 = 1'b1;
                            valid1_in   = 1'b1;
                            load_dirty1 = 1'b1;
                        end
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_victim    <= 1'b0;
            r_post_fill <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // The hit that completes a miss right after the fill is not a new hit event.
            r_post_fill <= (r_state == S_FILL) && pmem_resp;
            if (w_evt[1]) begin
                r_victim <= lru_out;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_evt[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign hit_count  = w_cnt[0];
    assign miss_count = w_cnt[1];
    assign wb_count   = w_cnt[2];

endmodule
